// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM / servo generator. One prescaler and one period counter are shared
// by all channels. Duty and mode are double-buffered and only change at a period boundary.
module pwm_multi_gen #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned RES      = 8,
  parameter int unsigned PRESC_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [RES-1:0]      cfg_wdata,
  input  logic                mode,
  input  logic [PRESC_W-1:0]  prescale,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);

  localparam int unsigned CW = RES + 5;
  localparam logic [CW-1:0] PWM_TERM   = CW'((1 << RES) - 1);
  localparam logic [CW-1:0] SERVO_TERM = CW'(20 * (1 << RES) - 1);
  localparam logic [CW-1:0] SERVO_BASE = CW'(1 << RES);

  typedef enum logic {MODE_PWM = 1'b0, MODE_SERVO = 1'b1} mode_e;

  mode_e                r_mode;
  logic [PRESC_W-1:0]   r_presc_cnt;
  logic [CW-1:0]        r_cnt;
  logic [RES-1:0]       r_pending [CHANNELS];
  logic [RES-1:0]       r_active  [CHANNELS];

  logic                 w_tick;
  logic                 w_wrap;
  logic [CW-1:0]        w_term;
  logic [CW-1:0]        w_thresh [CHANNELS];
  logic [CHANNELS-1:0]  w_cmp;

  // The >= compares let a live reduction of prescale (or a stale count) recover at once.
  always_comb begin
    w_tick = ena && (r_presc_cnt >= prescale);
    w_term = (r_mode == MODE_SERVO) ? SERVO_TERM : PWM_TERM;
    w_wrap = w_tick && (r_cnt >= w_term);
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_thresh[i] = ((r_mode == MODE_SERVO) ? SERVO_BASE : '0) + CW'(r_active[i]);
      w_cmp[i]    = r_cnt < w_thresh[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc_cnt <= '0;
      r_cnt       <= '0;
      period_tick <= 1'b0;
    end else if (!ena) begin
      r_presc_cnt <= '0;
      r_cnt       <= '0;
      period_tick <= 1'b0;
    end else begin
      r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PRESC_W'(1);
      if (w_tick) begin
        r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
      end
      period_tick <= w_wrap;
    end
  end

  // Active takes the pre-edge pending value, so a write on the wrap clk lands one period later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_PWM;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_pending[i] <= '0;
        r_active[i]  <= '0;
      end
    end else begin
      if (w_wrap) begin
        r_mode <= mode_e'(mode);
      end
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (w_wrap) begin
          r_active[i] <= r_pending[i];
        end
        if (cfg_we && (cfg_addr == 3'(i))) begin
          r_pending[i] <= cfg_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
    end else if (!ena) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= w_cmp;
    end
  end

endmodule
